nanorv32_csr_rmw: RTL and testbench

Read-modify-write sequencer that sits between the execute stage and the CSR register file. It accepts one decoded CSR instruction (CSRRW/CSRRS/CSRRC and their immediate forms) and reads the addressed CSR. It computes the new value and issues at most one write strobe. It returns the old CSR value for register-file writeback. While the operation is in progress it stalls the execute stage.

---
 rtl/nanorv32_csr_rmw_pkg.sv | 26 ++
 rtl/nanorv32_csr_rmw.sv | 152 +++++++++++++++
 tb/tb_nanorv32_csr_rmw.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nanorv32_csr_rmw_pkg.sv
// nanorv32_csr_rmw_pkg: shared constants for the CSR read-modify-write sequencer.
// Holds the CSR funct3 encodings, address/data MSBs, the read-only address field
// value and the sequencer FSM state encoding.
package nanorv32_csr_rmw_pkg;

    localparam int unsigned NANORV32_CSR_ADDR_MSB = 11;
    localparam int unsigned NANORV32_DATA_MSB     = 31;

    localparam logic [2:0] NANORV32_CSR_FUNCT3_RW  = 3'b001;
    localparam logic [2:0] NANORV32_CSR_FUNCT3_RS  = 3'b010;
    localparam logic [2:0] NANORV32_CSR_FUNCT3_RC  = 3'b011;
    localparam logic [2:0] NANORV32_CSR_FUNCT3_RWI = 3'b101;
    localparam logic [2:0] NANORV32_CSR_FUNCT3_RSI = 3'b110;
    localparam logic [2:0] NANORV32_CSR_FUNCT3_RCI = 3'b111;

    // addr[11:10] value marking a read-only CSR
    localparam logic [1:0] NANORV32_CSR_RO_FIELD = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } csr_state_e;

endpackage

// File: rtl/nanorv32_csr_rmw.sv
// nanorv32_csr_rmw: CSR read-modify-write sequencer between execute and the CSR file.
// Accepts one CSR instruction, reads the CSR, computes the new value, issues at most
// one write strobe and returns the old value, stalling execute while in progress.
//
// Optional build macro: NANORV32_CSR_ILLEGAL_CHECK_EN (flags funct3 000/100 and
// writes to read-only CSRs as illegal; otherwise csr_illegal is tied to 0).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   csr_op_*              decoded CSR instruction, held until csr_done
//   csr_core_rdata        combinational read data from the CSR file
//   core_csr_addr/wdata   address and write data to the CSR file
//   core_csr_write        single-cycle write strobe
//   csr_busy              stall request to the pipeline
//   csr_done, csr_rd_data completion pulse and old CSR value
//   csr_illegal           illegal-instruction pulse, coincident with csr_done
module nanorv32_csr_rmw
    import nanorv32_csr_rmw_pkg::*;
#(
    parameter int unsigned CSR_ADDR_W = NANORV32_CSR_ADDR_MSB + 1,
    parameter int unsigned DATA_W     = NANORV32_DATA_MSB + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csr_op_valid,
    input  logic [2:0]            csr_op_funct3,
    input  logic [CSR_ADDR_W-1:0] csr_op_addr,
    input  logic [DATA_W-1:0]     csr_op_rs1_data,
    input  logic [4:0]            csr_op_rs1_field,
    input  logic [DATA_W-1:0]     csr_core_rdata,
    output logic [CSR_ADDR_W-1:0] core_csr_addr,
    output logic [DATA_W-1:0]     core_csr_wdata,
    output logic                  core_csr_write,
    output logic                  csr_busy,
    output logic                  csr_done,
    output logic [DATA_W-1:0]     csr_rd_data,
    output logic                  csr_illegal
);

    csr_state_e              state_q;
    logic [2:0]              funct3_q;
    logic [CSR_ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]       rs1_data_q;
    logic [4:0]              rs1_field_q;
    logic [DATA_W-1:0]       old_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    write_q;
    logic                    done_q;
    logic                    illegal_q;

    logic [DATA_W-1:0]       operand;
    logic [DATA_W-1:0]       new_value;
    logic                    write_req;
    logic                    read_only;
    logic                    illegal;
    logic                    do_write;

    function automatic logic [DATA_W-1:0] csr_alu(input logic [2:0]        f3,
                                                  input logic [DATA_W-1:0] old,
                                                  input logic [DATA_W-1:0] opnd);
        case (f3)
            NANORV32_CSR_FUNCT3_RW,
            NANORV32_CSR_FUNCT3_RWI: csr_alu = opnd;
            NANORV32_CSR_FUNCT3_RS,
            NANORV32_CSR_FUNCT3_RSI: csr_alu = old | opnd;
            NANORV32_CSR_FUNCT3_RC,
            NANORV32_CSR_FUNCT3_RCI: csr_alu = old & ~opnd;
            default:                 csr_alu = old;
        endcase
    endfunction

    always_comb begin
        // funct3[2] selects the zero-extended zimm operand
        operand   = funct3_q[2] ? {{(DATA_W-5){1'b0}}, rs1_field_q} : rs1_data_q;
        new_value = csr_alu(funct3_q, csr_core_rdata, operand);
        // funct3 x00 is not a CSR read-modify-write form and never writes
        if (funct3_q == NANORV32_CSR_FUNCT3_RW || funct3_q == NANORV32_CSR_FUNCT3_RWI) begin
            write_req = 1'b1;
        end else begin
            write_req = (funct3_q[1:0] != 2'b00) && (rs1_field_q != 5'd0);
        end
        read_only = (addr_q[CSR_ADDR_W-1 -: 2] == NANORV32_CSR_RO_FIELD);
`ifdef NANORV32_CSR_ILLEGAL_CHECK_EN
        illegal = (funct3_q[1:0] == 2'b00) || (write_req && read_only);
`else
        illegal = 1'b0;
`endif
        do_write = write_req && !read_only && !illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            funct3_q    <= '0;
            addr_q      <= '0;
            rs1_data_q  <= '0;
            rs1_field_q <= '0;
            old_q       <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            write_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (csr_op_valid) begin
                        funct3_q    <= csr_op_funct3;
                        addr_q      <= csr_op_addr;
                        rs1_data_q  <= csr_op_rs1_data;
                        rs1_field_q <= csr_op_rs1_field;
                        state_q     <= StRead;
                    end
                end
                StRead: begin
                    old_q <= csr_core_rdata;
                    if (do_write) begin
                        wdata_q <= new_value;
                        write_q <= 1'b1;
                        state_q <= StWrite;
                    end else begin
                        done_q    <= 1'b1;
                        illegal_q <= illegal;
                        state_q   <= StDone;
                    end
                end
                StWrite: begin
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    // valid is still held by execute here, so it is not re-accepted
                    addr_q  <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign core_csr_addr  = addr_q;
    assign core_csr_wdata = wdata_q;
    assign core_csr_write = write_q;
    assign csr_done       = done_q;
    assign csr_rd_data    = old_q;
    assign csr_illegal    = illegal_q;
    assign csr_busy       = (state_q == StIdle && csr_op_valid) || state_q == StRead ||
                            state_q == StWrite;

endmodule

// File: tb/tb_nanorv32_csr_rmw.sv
// tb_nanorv32_csr_rmw: self-checking bench for nanorv32_csr_rmw.
// Directed cases plus randomized CSR ops checked against a behavioural model.
// Honors NANORV32_CSR_ILLEGAL_CHECK_EN for the expected illegal behaviour.
module tb_nanorv32_csr_rmw;

    logic        clk;
    logic        rst_n;
    logic        csr_op_valid;
    logic [2:0]  csr_op_funct3;
    logic [11:0] csr_op_addr;
    logic [31:0] csr_op_rs1_data;
    logic [4:0]  csr_op_rs1_field;
    logic [31:0] csr_core_rdata;
    logic [11:0] core_csr_addr;
    logic [31:0] core_csr_wdata;
    logic        core_csr_write;
    logic        csr_busy;
    logic        csr_done;
    logic [31:0] csr_rd_data;
    logic        csr_illegal;

    int n_cmp;
    int n_err;

    // CSR file stand-in: returns the CSR value only when addressed correctly
    logic [11:0] cur_addr;
    logic [31:0] cur_val;
    assign csr_core_rdata = (core_csr_addr == cur_addr) ? cur_val : ~cur_val;

    nanorv32_csr_rmw dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .csr_op_valid     (csr_op_valid),
        .csr_op_funct3    (csr_op_funct3),
        .csr_op_addr      (csr_op_addr),
        .csr_op_rs1_data  (csr_op_rs1_data),
        .csr_op_rs1_field (csr_op_rs1_field),
        .csr_core_rdata   (csr_core_rdata),
        .core_csr_addr    (core_csr_addr),
        .core_csr_wdata   (core_csr_wdata),
        .core_csr_write   (core_csr_write),
        .csr_busy         (csr_busy),
        .csr_done         (csr_done),
        .csr_rd_data      (csr_rd_data),
        .csr_illegal      (csr_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef NANORV32_CSR_ILLEGAL_CHECK_EN
    localparam bit IllegalCheck = 1'b1;
`else
    localparam bit IllegalCheck = 1'b0;
`endif

    // Reference model from the instruction semantics
    function automatic void model(input logic [2:0] f3, input logic [11:0] addr,
                                  input logic [31:0] rs1, input logic [4:0] fld,
                                  input logic [31:0] old, output bit wr,
                                  output logic [31:0] nv, output bit ill);
        logic [31:0] opnd;
        bit          wants;
        bit          ro;
        opnd = (f3 >= 3'd5) ? {27'd0, fld} : rs1;
        case (f3)
            3'd1, 3'd5: begin nv = opnd;        wants = 1'b1;        end
            3'd2, 3'd6: begin nv = old | opnd;  wants = (fld != 0);  end
            3'd3, 3'd7: begin nv = old & ~opnd; wants = (fld != 0);  end
            default:    begin nv = old;         wants = 1'b0;        end
        endcase
        ro  = (addr[11:10] == 2'b11);
        ill = IllegalCheck && (f3 == 3'd0 || f3 == 3'd4 || (wants && ro));
        wr  = wants && !ro && !ill;
    endfunction

    // Presents one op at a negedge and observes it until csr_done
    task automatic run_op(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                          input logic [4:0] fld, input logic [31:0] val, input bit hold,
                          output int lat, output int nwr, output logic [31:0] wd,
                          output logic [31:0] rd, output logic ill, output int busy_cnt,
                          output int addr_bad);
        cur_addr = addr;
        cur_val = val;
        csr_op_funct3 = f3;
        csr_op_addr = addr;
        csr_op_rs1_data = rs1;
        csr_op_rs1_field = fld;
        csr_op_valid = 1'b1;
        lat = 0; nwr = 0; wd = '0; rd = '0; ill = 1'b0; busy_cnt = 0; addr_bad = 0;
        #1;
        if (csr_busy) busy_cnt++;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (csr_busy) busy_cnt++;
            if (core_csr_addr !== addr) addr_bad++;
            if (core_csr_write === 1'b1) begin
                nwr++;
                wd = core_csr_wdata;
            end
            if (csr_done === 1'b1) begin
                lat = c;
                rd = csr_rd_data;
                ill = csr_illegal;
                break;
            end
        end
        if (lat == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL op_timeout: no csr_done within 10 cycles, required one");
        end
        if (!hold) begin
            csr_op_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        csr_op_valid = 1'b0;
        csr_op_funct3 = '0;
        csr_op_addr = '0;
        csr_op_rs1_data = '0;
        csr_op_rs1_field = '0;
        cur_addr = '0;
        cur_val = '0;
        #12;
        n_cmp++;
        if ({core_csr_write, csr_done, csr_illegal, csr_busy} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, required 0000",
                     {core_csr_write, csr_done, csr_illegal, csr_busy});
        end
        n_cmp++;
        if ({core_csr_addr, core_csr_wdata, csr_rd_data} !== 76'd0) begin
            n_err++;
            $display("FAIL reset_data: addr %h wdata %h rd %h, required all 0",
                     core_csr_addr, core_csr_wdata, csr_rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_csrrs_no_write();
        int lat, nwr, bc, ab;
        logic [31:0] wd, rd;
        logic ill;
        run_op(3'b010, 12'hC00, 32'hFFFF_FFFF, 5'd0, 32'h1234, 1'b0, lat, nwr, wd, rd, ill, bc,
               ab);
        n_cmp++;
        if (lat != 2 || nwr != 0) begin
            n_err++;
            $display("FAIL csrrs_flow: latency %0d writes %0d, required 2 and 0", lat, nwr);
        end
        n_cmp++;
        if (rd !== 32'h1234 || ill !== 1'b0) begin
            n_err++;
            $display("FAIL csrrs_result: rd %h illegal %b, required 00001234 and 0", rd, ill);
        end
    endtask

    task automatic test_csrrw();
        int lat, nwr, bc, ab;
        logic [31:0] wd, rd;
        logic ill;
        run_op(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd3, 32'h5, 1'b0, lat, nwr, wd, rd, ill, bc, ab);
        n_cmp++;
        if (lat != 3 || nwr != 1) begin
            n_err++;
            $display("FAIL csrrw_flow: latency %0d writes %0d, required 3 and 1", lat, nwr);
        end
        n_cmp++;
        if (wd !== 32'hDEAD_BEEF || rd !== 32'h5) begin
            n_err++;
            $display("FAIL csrrw_data: wdata %h rd %h, required deadbeef and 00000005", wd, rd);
        end
        n_cmp++;
        if (bc != 3 || ab != 0) begin
            n_err++;
            $display("FAIL csrrw_busy_addr: busy cycles %0d addr errors %0d, required 3 and 0",
                     bc, ab);
        end
    endtask

    task automatic test_csrrci();
        int lat, nwr, bc, ab;
        logic [31:0] wd, rd;
        logic ill;
        run_op(3'b111, 12'h300, 32'h0, 5'h0F, 32'hFFFF_00FF, 1'b0, lat, nwr, wd, rd, ill, bc, ab);
        n_cmp++;
        if (nwr != 1 || wd !== 32'hFFFF_00F0) begin
            n_err++;
            $display("FAIL csrrci_wdata: writes %0d wdata %h, required 1 and ffff00f0", nwr, wd);
        end
        n_cmp++;
        if (rd !== 32'hFFFF_00FF) begin
            n_err++;
            $display("FAIL csrrci_rd: got %h, required ffff00ff", rd);
        end
    endtask

    task automatic test_read_only();
        int lat, nwr, bc, ab;
        logic [31:0] wd, rd;
        logic ill;
        run_op(3'b001, 12'hC80, 32'hCAFE_F00D, 5'd1, 32'h77, 1'b0, lat, nwr, wd, rd, ill, bc, ab);
        n_cmp++;
        if (nwr != 0 || lat != 2) begin
            n_err++;
            $display("FAIL ro_no_strobe: writes %0d latency %0d, required 0 and 2", nwr, lat);
        end
        n_cmp++;
        if (ill !== IllegalCheck || rd !== 32'h77) begin
            n_err++;
            $display("FAIL ro_illegal: illegal %b rd %h, required %b and 00000077", ill, rd,
                     IllegalCheck);
        end
    endtask

    task automatic test_random();
        int lat, nwr, bc, ab;
        logic [31:0] wd, rd;
        logic ill;
        bit ewr, eill;
        logic [31:0] env;
        logic [2:0] f3;
        logic [11:0] addr;
        logic [31:0] rs1, val;
        logic [4:0] fld;
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            addr = 12'($urandom);
            if ($urandom_range(0, 3) == 0) addr[11:10] = 2'b11;
            if (addr == 12'h000) addr = 12'h001;
            rs1 = $urandom;
            fld = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            val = $urandom;
            model(f3, addr, rs1, fld, val, ewr, env, eill);
            run_op(f3, addr, rs1, fld, val, 1'b0, lat, nwr, wd, rd, ill, bc, ab);
            n_cmp++;
            if (lat != (ewr ? 3 : 2) || nwr != (ewr ? 1 : 0) || bc != lat || ab != 0) begin
                n_err++;
                $display("FAIL rand_flow[%0d] f3=%0d addr=%h fld=%0d: lat %0d wr %0d busy %0d ab %0d, required lat %0d wr %0d",
                         i, f3, addr, fld, lat, nwr, bc, ab, ewr ? 3 : 2, ewr ? 1 : 0);
            end
            n_cmp++;
            if ((ewr && wd !== env) || rd !== val || ill !== eill) begin
                n_err++;
                $display("FAIL rand_data[%0d] f3=%0d: wdata %h rd %h ill %b, required %h %h %b",
                         i, f3, wd, rd, ill, env, val, eill);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, nwr, bc, ab;
        logic [31:0] wd, rd;
        logic ill;
        int extra;
        run_op(3'b001, 12'h305, 32'h1111_2222, 5'd4, 32'hA5A5_0000, 1'b1, lat, nwr, wd, rd, ill,
               bc, ab);
        @(negedge clk);
        // valid still held: the DONE cycle must not have accepted the op again
        n_cmp++;
        if (core_csr_addr !== 12'h000 || csr_done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: addr %h done %b, required 000 and 0", core_csr_addr,
                     csr_done);
        end
        run_op(3'b110, 12'h341, 32'h0, 5'h12, 32'h0000_0F00, 1'b0, lat, nwr, wd, rd, ill, bc, ab);
        n_cmp++;
        if (lat != 3 || wd !== 32'h0000_0F12 || rd !== 32'h0000_0F00) begin
            n_err++;
            $display("FAIL b2b_second: lat %0d wdata %h rd %h, required 3 00000f12 00000f00",
                     lat, wd, rd);
        end
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (csr_done === 1'b1 || core_csr_write === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL b2b_extra_pulses: got %0d, required 0", extra);
        end
    endtask

    task automatic test_reset_mid_write();
        int seen;
        int late;
        cur_addr = 12'h340;
        cur_val = 32'h9;
        csr_op_funct3 = 3'b001;
        csr_op_addr = 12'h340;
        csr_op_rs1_data = 32'h1357_9BDF;
        csr_op_rs1_field = 5'd1;
        csr_op_valid = 1'b1;
        seen = 0;
        for (int c = 0; c < 6 && seen == 0; c++) begin
            @(negedge clk);
            if (core_csr_write === 1'b1) seen = 1;
        end
        n_cmp++;
        if (seen != 1) begin
            n_err++;
            $display("FAIL rst_reach_write: strobe seen %0d, required 1", seen);
        end
        rst_n = 1'b0;
        csr_op_valid = 1'b0;
        #1;
        n_cmp++;
        if ({core_csr_write, csr_done, csr_illegal, csr_busy} !== 4'b0 ||
            {core_csr_addr, core_csr_wdata, csr_rd_data} !== 76'd0) begin
            n_err++;
            $display("FAIL rst_mid_write: wr %b done %b ill %b busy %b addr %h wdata %h rd %h, required all 0",
                     core_csr_write, csr_done, csr_illegal, csr_busy, core_csr_addr,
                     core_csr_wdata, csr_rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        late = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (core_csr_write === 1'b1 || csr_done === 1'b1) late++;
        end
        n_cmp++;
        if (late != 0) begin
            n_err++;
            $display("FAIL rst_no_late_strobe: got %0d, required 0", late);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_csrrs_no_write();
        test_csrrw();
        test_csrrci();
        test_read_only();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
